pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a classic five-stage in-order pipeline. It watches the
// decode and execute stages plus the data-memory handshake and produces the
// per-stage enables, flushes and the PC redirect select. The controller is a
// small FSM (RUN / LDUSE / FLUSH / MWAIT) with a 4-bit bubble/flush counter.
// Outputs are combinational from state and current inputs, so a hazard
// stalls the pipeline in the same cycle it is detected.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : asynchronous, active-low reset
//   idValid      : decode stage holds a valid instruction
//   idSrc1/2     : decode-stage source register indices
//   idUsesSrc2   : decode-stage instruction reads idSrc2
//   exInstType   : execute-stage instruction type code
//   exRd         : execute-stage destination register
//   exRegWrEn    : execute-stage instruction writes exRd
//   exBrTaken    : execute-stage branch resolved taken
//   memReq       : data-memory request outstanding
//   memReady     : data-memory request completes this cycle
//   pcEn         : PC register enable
//   pcRedirect   : select the branch/jump target as next PC
//   ifIdEn       : IF/ID register enable
//   ifIdFlush    : IF/ID register flush (insert bubble)
//   idExEn       : ID/EX register enable
//   idExFlush    : ID/EX register flush (insert bubble)
//   exMemEn      : EX/MEM register enable
//   ctrlState    : current FSM state (RUN=0, LDUSE=1, FLUSH=2, MWAIT=3)
//   stallCycles  : saturating count of cycles with pcEn=0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter logic [3:0] OP1_LW       = 4'h9,
  parameter logic [3:0] OP1_BR       = 4'h2,
  parameter logic [3:0] OP1_JAL      = 4'hB,
  parameter int         LOAD_BUBBLES = 1,
  parameter int         FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idValid,
  input  logic [3:0]  idSrc1,
  input  logic [3:0]  idSrc2,
  input  logic        idUsesSrc2,
  input  logic [3:0]  exInstType,
  input  logic [3:0]  exRd,
  input  logic        exRegWrEn,
  input  logic        exBrTaken,
  input  logic        memReq,
  input  logic        memReady,
  output logic        pcEn,
  output logic        pcRedirect,
  output logic        ifIdEn,
  output logic        ifIdFlush,
  output logic        idExEn,
  output logic        idExFlush,
  output logic        exMemEn,
  output logic [1:0]  ctrlState,
  output logic [15:0] stallCycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    FLUSH = 2'd2,
    MWAIT = 2'd3
  } ctrlStateT;

  // The first bubble/flush cycle is issued from RUN, so the counter only
  // covers the remaining cycles.
  localparam logic [3:0] LOAD_CNT  = 4'(LOAD_BUBBLES - 1);
  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES - 1);

  ctrlStateT   stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic [15:0] stallQ;

  logic memHold;
  logic redirect;
  logic loadUse;

  assign memHold  = memReq & ~memReady;
  assign redirect = (exInstType == OP1_JAL) | ((exInstType == OP1_BR) & exBrTaken);
  assign loadUse  = (exInstType == OP1_LW) & exRegWrEn & (exRd != 4'd0) & idValid &
                    ((exRd == idSrc1) | (idUsesSrc2 & (exRd == idSrc2)));

  // NOTE: every output and next-state variable gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    pcEn       = 1'b1;
    pcRedirect = 1'b0;
    ifIdEn     = 1'b1;
    ifIdFlush  = 1'b0;
    idExEn     = 1'b1;
    idExFlush  = 1'b0;
    exMemEn    = 1'b1;
    stateD     = stateQ;
    cntD       = cntQ;

    if (memHold) begin
      // A stalled memory access freezes everything; LDUSE/FLUSH keep their
      // count so the sequence resumes where it left off.
      pcEn    = 1'b0;
      ifIdEn  = 1'b0;
      idExEn  = 1'b0;
      exMemEn = 1'b0;
      if (stateQ == RUN) stateD = MWAIT;
    end else begin
      unique case (stateQ)
        // MWAIT releasing behaves exactly like RUN, so a hazard that was
        // waiting behind the memory stall is serviced in the release cycle.
        RUN, MWAIT: begin
          stateD = RUN;
          if (redirect) begin
            pcRedirect = 1'b1;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              stateD = FLUSH;
              cntD   = FLUSH_CNT;
            end
          end else if (loadUse) begin
            pcEn      = 1'b0;
            ifIdEn    = 1'b0;
            idExFlush = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              stateD = LDUSE;
              cntD   = LOAD_CNT;
            end
          end
        end
        LDUSE: begin
          pcEn      = 1'b0;
          ifIdEn    = 1'b0;
          idExFlush = 1'b1;
          cntD      = cntQ - 4'd1;
          if (cntQ <= 4'd1) begin
            stateD = RUN;
            cntD   = 4'd0;
          end
        end
        FLUSH: begin
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
          cntD      = cntQ - 4'd1;
          if (cntQ <= 4'd1) begin
            stateD = RUN;
            cntD   = 4'd0;
          end
        end
        default: begin
          stateD = RUN;
          cntD   = 4'd0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; the reset branch is asynchronous, which lets
  // a reset abandon any sequence without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= RUN;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Stall counter saturates so a long run never wraps back to a small value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallQ <= 16'd0;
    end else if (!pcEn && (stallQ != 16'hFFFF)) begin
      stallQ <= stallQ + 16'd1;
    end
  end

  assign ctrlState   = stateQ;
  assign stallCycles = stallQ;

endmodule
